// File: rtl/axi_defines.sv
// Shared AXI4-Lite definitions: response codes and the
// SRAM slave state encoding.
package axi_defines;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t AXIL_RESP_OKAY   = 2'b00;
  localparam axil_resp_t AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WCOLLECT,
    WEXEC,
    BRESP,
    RREAD,
    RRESP
  } axil_slv_state_t;

endpackage

// File: rtl/sram_sp_be.sv
// Single-port DEPTH x 32 RAM with byte write enables and a
// registered read port; no reset so it maps onto block RAM.
module sram_sp_be #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave backed by one single-port byte-enabled SRAM.
// Define AXIL_SLV_RANGE_CHECK_EN to answer out-of-window accesses with SLVERR.
module axil_sram_slave
  import axi_defines::*;
#(
  parameter int          MEM_DEPTH = 4096,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axil_awaddr,
  input  logic [2:0]  s_axil_awprot,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [31:0] s_axil_araddr,
  input  logic [2:0]  s_axil_arprot,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready
);

  localparam int AW = $clog2(MEM_DEPTH);

  axil_slv_state_t state, state_nxt;

  logic          aw_held, w_held, rd_prio;
  logic          wr_err, rd_err;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   aw_off, ar_off;
  logic          aw_oor, ar_oor;
  logic          grant_rd, collect;
  logic          aw_hs, w_hs;
  logic          ram_re;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          unused_bits;

  assign aw_off = s_axil_awaddr - ADDR_BASE;
  assign ar_off = s_axil_araddr - ADDR_BASE;

`ifdef AXIL_SLV_RANGE_CHECK_EN
  localparam logic [32:0] SPAN = 33'(MEM_DEPTH) << 2;
  assign aw_oor = (s_axil_awaddr < ADDR_BASE)
               || ({1'b0, aw_off} >= SPAN);
  assign ar_oor = (s_axil_araddr < ADDR_BASE)
               || ({1'b0, ar_off} >= SPAN);
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                         aw_off, ar_off};

  // Reset masks every ready/valid so a held reset is quiet.
  assign grant_rd = !rst && (state == IDLE) && s_axil_arvalid
                 && (rd_prio || !(s_axil_awvalid || s_axil_wvalid));
  assign collect  = !rst && ((state == IDLE) || (state == WCOLLECT));

  assign s_axil_awready = collect && !aw_held && !grant_rd;
  assign s_axil_wready  = collect && !w_held && !grant_rd;
  assign s_axil_arready = grant_rd;

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_rd) begin
          state_nxt = RREAD;
        end else if (aw_hs && w_hs) begin
          state_nxt = WEXEC;
        end else if (aw_hs || w_hs) begin
          state_nxt = WCOLLECT;
        end
      end
      WCOLLECT: begin
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          state_nxt = WEXEC;
        end
      end
      WEXEC: state_nxt = BRESP;
      BRESP: begin
        if (s_axil_bready) begin
          state_nxt = IDLE;
        end
      end
      RREAD: state_nxt = RRESP;
      RRESP: begin
        if (s_axil_rready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      rd_prio <= 1'b0;
    end else begin
      state <= state_nxt;
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
      if (state == WEXEC) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        rd_prio <= 1'b1;
      end
      if (state == RREAD) rd_prio <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      wr_idx <= aw_off[AW+1:2];
      wr_err <= aw_oor;
    end
    if (w_hs) begin
      wdata_q <= s_axil_wdata;
      wstrb_q <= s_axil_wstrb;
    end
    if (grant_rd) begin
      rd_idx <= ar_off[AW+1:2];
      rd_err <= ar_oor;
    end
  end

  assign ram_re   = !rst && (state == RREAD);
  assign ram_we   = (!rst && (state == WEXEC) && !wr_err)
                  ? wstrb_q : 4'h0;
  assign ram_addr = (state == RREAD) ? rd_idx : wr_idx;

  sram_sp_be #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign s_axil_bvalid = !rst && (state == BRESP);
  assign s_axil_rvalid = !rst && (state == RRESP);

  assign s_axil_bresp = (s_axil_bvalid && wr_err)
                      ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
  assign s_axil_rresp = (s_axil_rvalid && rd_err)
                      ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
  assign s_axil_rdata = (s_axil_rvalid && !rd_err)
                      ? ram_rdata : 32'h0;

endmodule
